// File: rtl/uart_pkg.sv
// Shared state encodings and defaults for uart_core.
// UART_PARITY_EN adds the PARITY states to both FSM encodings.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 4231;  // 81.25 MHz / 19200 baud

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  // Words narrower than 8 bits are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity_of(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with registered storage and an always-visible head word.
// Written generically so it can also serve as a TX buffer later.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: independent TX and RX FSMs plus a receive FIFO with valid/ready handshakes.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd) and the rx_parity_err port.
//
// RX state      | meaning
// RX_IDLE       | line high, waiting for a falling edge
// RX_START      | timing to mid start bit, rejects glitches
// RX_DATA       | sampling data bits mid-bit, LSB first
// RX_PARITY     | checking parity bit (UART_PARITY_EN only)
// RX_STOP       | sampling stop bit, pushes word or flags framing error
// RX_WAIT_HIGH  | after framing error, waits out a break
//
// TX state      | meaning
// TX_IDLE       | tx_ready high, accepts a word
// TX_START      | driving start bit
// TX_DATA       | shifting data bits, LSB first
// TX_PARITY     | driving parity bit (UART_PARITY_EN only)
// TX_STOP       | driving stop bit(s)
module uart_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int RX_DEPTH     = 4
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
`ifdef UART_PARITY_EN
  output logic                 rx_parity_err,
`endif
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF      = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_STOP_LAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST      = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST     = 1'(STOP_BITS - 1);

  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_tick;
  logic                 rx_push;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign rx_tick = (rx_cnt == CNT_LAST);

`ifdef UART_PARITY_EN
  logic rx_par_bad;
  assign rx_push = (rx_state == RX_STOP) && rx_tick && rx_s && !rx_par_bad;
`else
  assign rx_push = (rx_state == RX_STOP) && rx_tick && rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      rx_cnt <= rx_tick ? '0 : rx_cnt + CW'(1);
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s) rx_state <= RX_START;
        end
        RX_START: begin
          // Re-check at mid start bit; a high line here was a glitch.
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + BW'(1);
            if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_tick) begin
            rx_par_bad    <= (rx_s != parity_of(8'(rx_shift), PARITY_ODD));
            rx_parity_err <= (rx_s != parity_of(8'(rx_shift), PARITY_ODD));
            rx_state      <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (rx_tick) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_ready),
    .head      (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid = !fifo_empty;

  // When full the FIFO is non-empty, so rx_ready alone means a pop makes room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_push && fifo_full && !rx_ready;
    end
  end

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_stop_idx;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt == CNT_LAST);

`ifdef UART_PARITY_EN
  logic tx_par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state    <= TX_IDLE;
      tx          <= 1'b1;
      tx_ready    <= 1'b1;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_shift    <= '0;
      tx_stop_idx <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par      <= 1'b0;
`endif
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + CW'(1);
      unique case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (tx_valid) begin
            tx_shift <= tx_data;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= TX_START;
`ifdef UART_PARITY_EN
            tx_par   <= parity_of(8'(tx_data), PARITY_ODD);
`endif
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx       <= tx_shift[0];
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + BW'(1);
            if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
              tx       <= tx_par;
              tx_state <= TX_PARITY;
`else
              tx          <= 1'b1;
              tx_stop_idx <= 1'b0;
              tx_state    <= TX_STOP;
`endif
            end else begin
              tx <= tx_shift[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_tick) begin
            tx          <= 1'b1;
            tx_stop_idx <= 1'b0;
            tx_state    <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          // The IDLE cycle counts as the last stop cycle, so back-to-back frames
          // see exactly STOP_BITS*CLKS_PER_BIT high cycles between them.
          if (tx_stop_idx == STOP_LAST && tx_cnt == CNT_STOP_LAST) begin
            tx_ready <= 1'b1;
            tx_state <= TX_IDLE;
          end else if (tx_tick) begin
            tx_stop_idx <= tx_stop_idx + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at 16 clks/bit, 8 data bits, 2 TX stop bits, 4-deep RX FIFO.
module tb_uart_core;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_drv;
  logic       loop_en;
  logic       rx_line;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int n;
  int rdy;
  int lows;
  logic [9:0] wave;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_core #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (2),
    .RX_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx_line),
    .tx           (tx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) fe_cnt++;
    if (rx_overrun === 1'b1) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; leaves the line at the stop value.
  task automatic send_frame(input logic [7:0] d, input logic stop_val);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx_drv = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_val;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, rx_valid, 1);
    chk({tag, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (!rx_valid && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_wait"}, rx_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    rx_drv   = 1'b1;
    loop_en  = 1'b0;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_ovr", rx_overrun, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5: start, A5 LSB first, stop.
    loop_en  = 1'b1;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("lb_tx_start", tx, 0);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      wave[k] = tx;
      repeat (CPB) @(negedge clk);
    end
    chk("lb_wave", wave, 10'h34A);
    wait_valid("lb", 100);
    pop_expect("lb_pop", 8'hA5);
    chk("lb_empty", rx_valid, 0);
    n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("lb_tx_ready", tx_ready, 1);
    loop_en = 1'b0;
    repeat (4) @(negedge clk);

    // Glitch: 5-clk low pulse is rejected, receiver still takes the next frame.
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("gl_valid", rx_valid, 0);
    chk("gl_ferr", fe_cnt, 0);
    send_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    pop_expect("gl_next", 8'h5A);

    // Framing error with line held low, then recovery.
    send_frame(8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    chk("fr_ferr", fe_cnt, 1);
    chk("fr_valid", rx_valid, 0);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    chk("fr_ferr_after", fe_cnt, 1);
    pop_expect("fr_next", 8'h3C);
    chk("fr_empty", rx_valid, 0);

    // Overrun: five words into a 4-deep FIFO with no pops.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    chk("ov_none_yet", ov_cnt, 0);
    send_frame(8'h05, 1'b1);
    repeat (4) @(negedge clk);
    chk("ov_pulse", ov_cnt, 1);
    for (int i = 1; i <= 4; i++) pop_expect("ov_pop", 8'(i));
    chk("ov_empty", rx_valid, 0);

    // Full + pop in the push cycle of the fifth word: no overrun.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("fp_no_ovr", ov_cnt, 1);
    for (int i = 2; i <= 5; i++) pop_expect("fp_pop", 8'(i));
    chk("fp_empty", rx_valid, 0);

    // TX back-to-back 0x00 then 0xFF with tx_valid held; data change mid-frame ignored.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hFF;
    n = 0;
    while (tx == 1'b0 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_low0", n, 144);
    n   = 0;
    rdy = 0;
    while (tx == 1'b1 && n < 400) begin
      if (tx_ready) rdy++;
      n++;
      @(negedge clk);
    end
    chk("b2b_gap", n, 32);
    chk("b2b_rdy", rdy, 1);
    tx_valid = 1'b0;
    n = 0;
    while (tx == 1'b0 && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_low1", n, 16);
    lows = 0;
    repeat (10 * CPB - 1) begin
      if (!tx) lows++;
      @(negedge clk);
    end
    chk("b2b_ff_lows", lows, 0);
    repeat (2) @(negedge clk);
    chk("b2b_ready", tx_ready, 1);

    // Reset in the middle of a frame forces tx high at once.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_tx_low", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_rdy", tx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_tx", tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised full-duplex UART: one transmitter and one receiver, plus a receive FIFO so the host can tolerate back-pressure.
- Next generation of the fixed 8N1 byte UART in the debug/console path. Adds configurable baud divisor, word length, stop bits and RX buffering.
- Adds false-start rejection, framing and overrun reporting, and valid/ready handshakes on both sides.

Parameters:
- CLKS_PER_BIT, 4231, clk cycles per bit (81.25 MHz -> ~19200 baud); legal range 4..65535.
- DATA_BITS, 8, word length; legal 5..8.
- STOP_BITS, 1, transmitted stop bits; legal 1 or 2. RX always checks exactly one.
- RX_DEPTH, 4, RX FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output
- rx_data  out  DATA_BITS  FIFO head word
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  host pops the head when rx_valid && rx_ready
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
- rx_overrun  out  1  one-cycle pulse: word dropped because FIFO full
- tx_data  in  DATA_BITS  word to send
- tx_valid  in  1  host offers tx_data
- tx_ready  out  1  transmitter idle; word accepted when tx_valid && tx_ready

Behaviour:
- Reset (async assert, sync deassert by the system):
  - Outputs: tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_frame_err=0, rx_overrun=0.
  - Internal state: both FSMs go to IDLE, FIFO empties, synchroniser flops go to 1.
  - Reset mid-frame: the frame is abandoned and tx returns to 1 immediately.
- Bit counter width is $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, then wraps.
- RX input conditioning: 2-flop synchroniser. All RX decisions use the synchronised signal rx_s.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1 re-sample rx_s.
    - rx_s==1 -> glitch; return to IDLE, no outputs.
    - rx_s==0 -> DATA, counter cleared.
  - DATA: sample rx_s each time count reaches CLKS_PER_BIT-1 (mid-bit). Bits arrive LSB first and shift into a DATA_BITS shift register. After DATA_BITS samples -> STOP.
  - STOP: sample mid-bit.
    - rx_s==1 -> push word, go to IDLE.
    - rx_s==0 -> pulse rx_frame_err for 1 cycle, discard the word, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. Covers line break.
- RX FIFO:
  - rx_valid = !empty. rx_data is the registered head, valid the same cycle rx_valid is high.
  - Push attempted when full: word dropped, rx_overrun pulses 1 cycle, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Push and pop in the same cycle while empty: push only. Pop is illegal because rx_valid=0.
  - Pointers are $clog2(RX_DEPTH)+1 bits with natural wrap. full/empty are derived from the MSB compare.
- RX latency: rx_valid rises 1 clk after the mid-stop sample, which is 2 clks after the line transition via the synchroniser.
- TX FSM states: IDLE, START, DATA, STOP.
  - tx_ready=1 only in IDLE.
  - On accept: latch tx_data, go to START. tx=0 from the next cycle for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE. tx_ready rises the following cycle.
  - Back-to-back words: tx_valid held high gives frames with no idle gap beyond the stop bits.
  - tx_data changes while busy are ignored.
- RX and TX are fully independent. Simultaneous activity must not interact.

Optional Feature:
- Macro: UART_PARITY_EN. When defined:
  - Adds parameter PARITY_ODD (default 0 = even) and output port rx_parity_err (1 bit, resets to 0).
  - TX and RX FSMs each gain a PARITY state between DATA and STOP.
  - TX sends the XOR of the data bits, inverted if PARITY_ODD.
  - RX checks the parity bit. On mismatch: pulse rx_parity_err for 1 cycle, discard the word, still check stop.
  - If both errors occur, both pulses are allowed.
- When undefined: no parity state, no port, frame is start+DATA_BITS+stop(s).

Decomposition:
- Package uart_pkg holds:
  - RX state enum (IDLE/START/DATA/STOP/WAIT_HIGH) and TX state enum (IDLE/START/DATA/STOP), plus PARITY entries under the macro.
  - Default constant for CLKS_PER_BIT at 81.25 MHz/19200.
- One sub-module, uart_rx_fifo: parametrised by width and depth, push/pop/full/empty. It is reusable for a future TX FIFO.
- TX and RX FSMs live in uart_core.

Test Plan:
- Run the bench with CLKS_PER_BIT=16 and DATA_BITS=8.
- Loopback: tx tied to rx, send 0xA5 -> rx_valid after one frame with rx_data=0xA5. tx waveform is 0,1,0,1,0,0,1,0,1,1 at 16 clks each.
- Glitch: drive rx low for 5 clks then high -> no rx_valid, rx_frame_err stays 0, RX FSM back in IDLE.
- Framing: send 0x3C with stop bit 0 -> rx_frame_err 1-cycle pulse, FIFO stays empty. rx held low 100 clks then high -> next 0x3C received correctly.
- Overrun: rx_ready=0, RX_DEPTH=4, send 0x01..0x05 -> rx_overrun pulses once on 0x05. Popping yields 0x01..0x04 in order.
- Full+pop: FIFO full, assert rx_ready exactly when the 5th word lands -> no overrun, subsequent pops return 0x02..0x05.
- TX back-to-back with STOP_BITS=2: hold tx_valid, send 0x00 then 0xFF -> 32 clks high between frames, tx_ready high 1 cycle after each final stop. Reset mid-frame -> tx=1 immediately.
